// File: rtl/core_arb_pkg.sv
// Shared types and sizing helpers for the multi-core memory arbiter.
package core_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Index width that stays at least one bit wide so a single-core build still has a grant port.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the memory model (slave).
interface core_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] wb;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, addr, wb, wdata, input rdata);
  modport slave  (input req, addr, wb, wdata, output rdata);
endinterface

// File: rtl/core_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter
  import core_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int GRANT_W   = grant_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [GRANT_W-1:0]   ptr_i,
  output logic [NUM_CORES-1:0] gnt_oh_o,
  output logic [GRANT_W-1:0]   gnt_idx_o,
  output logic                 any_req_o
);

  logic               found;
  logic [GRANT_W-1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    any_req_o = |req_i;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = GRANT_W'((int'(ptr_i) + i) % NUM_CORES);
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_oh_o[idx]  = 1'b1;
        gnt_idx_o      = idx;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin sharing of one single-port memory among NUM_CORES stalled cores.
// Optional per-core stall counters are built when CORE_ARB_STATS_EN is defined.
//   state | meaning
//   IDLE  | waiting for any request; winner's fields latched on exit
//   ISSUE | mem_req_o high for this one cycle; latency count loaded
//   WAIT  | counting down memory latency; read data captured at zero
//   DONE  | granted core released for this cycle; pointer advanced
module core_mem_arbiter
  import core_arb_pkg::*;
#(
  parameter int  NUM_CORES   = 4,
  parameter int  ADDR_WIDTH  = 32,
  parameter int  DATA_WIDTH  = 32,
  parameter int  MEM_LATENCY = 1,
  localparam int GRANT_W     = grant_w(NUM_CORES)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_CORES-1:0]                   core_req_i,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [NUM_CORES-1:0][DATA_WIDTH/8-1:0] core_wb_i,
  input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]   core_data_i,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0]   core_data_o,
  output logic [NUM_CORES-1:0]                   core_stall_o,
  core_mem_arbiter_if.master                     mem,
  output logic [GRANT_W-1:0]                     grant_o,
  output logic                                   busy_o,
  output logic [NUM_CORES-1:0][31:0]             stat_stall_o
);

  localparam int LAT_W = grant_w(MEM_LATENCY);

  arb_state_t                            state_q, state_d;
  logic [GRANT_W-1:0]                    ptr_q, ptr_d;
  logic [GRANT_W-1:0]                    grant_q, grant_d;
  logic [LAT_W-1:0]                      lat_q, lat_d;
  logic                                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
  logic [DATA_WIDTH/8-1:0]               wb_q, wb_d;
  logic [DATA_WIDTH-1:0]                 wdata_q, wdata_d;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  cdata_q, cdata_d;

  logic [NUM_CORES-1:0] win_oh;
  logic [GRANT_W-1:0]   win_idx;
  logic                 any_req;
  logic [NUM_CORES-1:0] done_oh;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .GRANT_W   (GRANT_W)
  ) u_rr (
    .req_i     (core_req_i),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (win_oh),
    .gnt_idx_o (win_idx),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    lat_d     = lat_q;
    mem_req_d = 1'b0;
    addr_d    = addr_q;
    wb_d      = wb_q;
    wdata_d   = wdata_q;
    cdata_d   = cdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = ISSUE;
          grant_d   = win_idx;
          mem_req_d = 1'b1;
          for (int n = 0; n < NUM_CORES; n++) begin
            if (win_oh[n]) begin
              addr_d  = core_addr_i[n];
              wb_d    = core_wb_i[n];
              wdata_d = core_data_i[n];
            end
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = LAT_W'(MEM_LATENCY - 1);
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = DONE;
          // Writes leave the core's read-data register untouched.
          if (wb_q == '0) cdata_d[grant_q] = mem.rdata;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (int'(grant_q) == NUM_CORES - 1) ? '0 : grant_q + GRANT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      lat_q     <= '0;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      wb_q      <= '0;
      wdata_q   <= '0;
      cdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      lat_q     <= lat_d;
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
      wb_q      <= wb_d;
      wdata_q   <= wdata_d;
      cdata_q   <= cdata_d;
    end
  end

  always_comb begin
    done_oh = '0;
    if (state_q == DONE) done_oh[grant_q] = 1'b1;
  end

  assign core_stall_o = core_req_i & ~done_oh;
  assign core_data_o  = cdata_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != IDLE);
  assign mem.req      = mem_req_q;
  assign mem.addr     = addr_q;
  assign mem.wb       = wb_q;
  assign mem.wdata    = wdata_q;

`ifdef CORE_ARB_STATS_EN
  logic [NUM_CORES-1:0][31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (core_stall_o[n] && stat_q[n] != 32'hFFFF_FFFF) stat_d[n] = stat_q[n] + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_stall_o = stat_q;
`else
  assign stat_stall_o = '0;
`endif

  // The access completes regardless, but the granted core must hold its request until released.
  a_req_held: assert property (@(posedge clock) disable iff (reset)
    (state_q == ISSUE || state_q == WAIT) |-> core_req_i[grant_q]);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed cycle-table bench for core_mem_arbiter plus reset and stall-counter sequences.
module tb_core_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WB = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]          core_req;
  logic [N-1:0][AW-1:0]  core_addr;
  logic [N-1:0][WB-1:0]  core_wb;
  logic [N-1:0][DW-1:0]  core_wdata;
  logic [N-1:0][DW-1:0]  core_rdata;
  logic [N-1:0]          core_stall;
  logic [1:0]            grant;
  logic                  busy;
  logic [N-1:0][31:0]    stat;

  core_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  core_mem_arbiter #(
    .NUM_CORES   (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_LATENCY (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .core_req_i   (core_req),
    .core_addr_i  (core_addr),
    .core_wb_i    (core_wb),
    .core_data_i  (core_wdata),
    .core_data_o  (core_rdata),
    .core_stall_o (core_stall),
    .mem          (mem_if),
    .grant_o      (grant),
    .busy_o       (busy),
    .stat_stall_o (stat)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] rdata;
    logic [3:0]  stall;
    logic        mreq;
    logic [1:0]  grant;
    logic        busy;
    logic [31:0] cd0;
    logic [31:0] cd2;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic [31:0] rdata,
                     input logic [3:0] stall, input logic mreq, input logic [1:0] g,
                     input logic bsy, input logic [31:0] cd0, input logic [31:0] cd2);
    vec_t v;
    v.rst = rst; v.req = req; v.rdata = rdata; v.stall = stall; v.mreq = mreq;
    v.grant = g; v.busy = bsy; v.cd0 = cd0; v.cd2 = cd2;
    tv.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic [31:0] d);
    @(posedge clock);
    #1;
    reset        = r;
    core_req     = q;
    mem_if.rdata = d;
    @(negedge clock);
  endtask

  initial begin
    core_addr  = {32'h0000_00C0, 32'h0000_0100, 32'h0000_0080, 32'h0000_0040};
    core_wb    = {4'b0000, 4'b0011, 4'b0000, 4'b0000};
    core_wdata = {32'hC3C3_C3C3, 32'h1234_5678, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    core_req     = '0;
    mem_if.rdata = '0;
    reset        = 1'b1;

    //   rst req      rdata         stall   mreq g  busy cd0           cd2
    add(0, 4'b0001, 32'h0,         4'b0001, 0, 0, 0, 32'h0,         32'h0);
    add(0, 4'b0001, 32'h0,         4'b0001, 1, 0, 1, 32'h0,         32'h0);
    add(0, 4'b0001, 32'hDEAD_BEEF, 4'b0001, 0, 0, 1, 32'h0,         32'h0);
    add(0, 4'b0001, 32'h0,         4'b0000, 0, 0, 1, 32'hDEAD_BEEF, 32'h0);
    add(0, 4'b0100, 32'h0,         4'b0100, 0, 0, 0, 32'hDEAD_BEEF, 32'h0);
    add(0, 4'b0100, 32'h0,         4'b0100, 1, 2, 1, 32'hDEAD_BEEF, 32'h0);
    add(0, 4'b0100, 32'hBAD0_BAD0, 4'b0100, 0, 2, 1, 32'hDEAD_BEEF, 32'h0);
    add(0, 4'b0100, 32'h0,         4'b0000, 0, 2, 1, 32'hDEAD_BEEF, 32'h0);
    add(1, 4'b0000, 32'h0,         4'b0000, 0, 2, 0, 32'hDEAD_BEEF, 32'h0);
    add(0, 4'b1111, 32'h0,         4'b1111, 0, 0, 0, 32'h0,         32'h0);
    add(0, 4'b1111, 32'h0,         4'b1111, 1, 0, 1, 32'h0,         32'h0);
    add(0, 4'b1111, 32'h1111_0000, 4'b1111, 0, 0, 1, 32'h0,         32'h0);
    add(0, 4'b1111, 32'h0,         4'b1110, 0, 0, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1110, 32'h0,         4'b1110, 0, 0, 0, 32'h1111_0000, 32'h0);
    add(0, 4'b1110, 32'h0,         4'b1110, 1, 1, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1110, 32'h2222_0000, 4'b1110, 0, 1, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1110, 32'h0,         4'b1100, 0, 1, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1100, 32'h0,         4'b1100, 0, 1, 0, 32'h1111_0000, 32'h0);
    add(0, 4'b1100, 32'h0,         4'b1100, 1, 2, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1100, 32'h3333_0000, 4'b1100, 0, 2, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1100, 32'h0,         4'b1000, 0, 2, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1000, 32'h0,         4'b1000, 0, 2, 0, 32'h1111_0000, 32'h0);
    add(0, 4'b1000, 32'h0,         4'b1000, 1, 3, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1000, 32'h4444_0000, 4'b1000, 0, 3, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1000, 32'h0,         4'b0000, 0, 3, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1001, 32'h0,         4'b1001, 0, 3, 0, 32'h1111_0000, 32'h0);
    add(0, 4'b1001, 32'h0,         4'b1001, 1, 0, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1001, 32'h5555_5555, 4'b1001, 0, 0, 1, 32'h1111_0000, 32'h0);
    add(0, 4'b1001, 32'h0,         4'b1000, 0, 0, 1, 32'h5555_5555, 32'h0);
    add(0, 4'b1000, 32'h0,         4'b1000, 0, 0, 0, 32'h5555_5555, 32'h0);
    add(0, 4'b1000, 32'h0,         4'b1000, 1, 3, 1, 32'h5555_5555, 32'h0);
    add(0, 4'b1000, 32'h6666_6666, 4'b1000, 0, 3, 1, 32'h5555_5555, 32'h0);
    add(0, 4'b1000, 32'h0,         4'b0000, 0, 3, 1, 32'h5555_5555, 32'h0);
    add(0, 4'b0000, 32'h0,         4'b0000, 0, 3, 0, 32'h5555_5555, 32'h0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst busy", 32'(busy), 32'h0);
    check("rst grant", 32'(grant), 32'h0);
    check("rst mem_req", 32'(mem_if.req), 32'h0);
    check("rst mem_addr", mem_if.addr, 32'h0);
    check("rst mem_wb", 32'(mem_if.wb), 32'h0);
    check("rst mem_wdata", mem_if.wdata, 32'h0);
    check("rst stall", 32'(core_stall), 32'h0);
    for (int n = 0; n < N; n++) begin
      check($sformatf("rst core_data[%0d]", n), core_rdata[n], 32'h0);
      check($sformatf("rst stat[%0d]", n), stat[n], 32'h0);
    end

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].req, tv[i].rdata);
      check($sformatf("v%0d stall", i), 32'(core_stall), 32'(tv[i].stall));
      check($sformatf("v%0d mem_req", i), 32'(mem_if.req), 32'(tv[i].mreq));
      check($sformatf("v%0d grant", i), 32'(grant), 32'(tv[i].grant));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].busy));
      check($sformatf("v%0d core_data[0]", i), core_rdata[0], tv[i].cd0);
      check($sformatf("v%0d core_data[2]", i), core_rdata[2], tv[i].cd2);
      if (tv[i].mreq) begin
        check($sformatf("v%0d mem_addr", i), mem_if.addr, core_addr[tv[i].grant]);
        check($sformatf("v%0d mem_wb", i), 32'(mem_if.wb), 32'(core_wb[tv[i].grant]));
        check($sformatf("v%0d mem_wdata", i), mem_if.wdata, core_wdata[tv[i].grant]);
      end
    end

    // Reset while waiting on the memory: the late response must not land anywhere.
    step(0, 4'b0001, 32'h0);
    step(0, 4'b0001, 32'h0);
    check("rw issue mem_req", 32'(mem_if.req), 32'h1);
    step(1, 4'b0001, 32'hFEED_FACE);
    check("rw wait busy", 32'(busy), 32'h1);
    step(0, 4'b0000, 32'hFEED_FACE);
    check("rw busy", 32'(busy), 32'h0);
    check("rw mem_req", 32'(mem_if.req), 32'h0);
    check("rw stall", 32'(core_stall), 32'h0);
    check("rw core_data[0]", core_rdata[0], 32'h0);
    step(0, 4'b0010, 32'h0);
    check("rw stall follows req", 32'(core_stall), 32'h2);
    check("rw idle busy", 32'(busy), 32'h0);
    check("rw core_data[0] late", core_rdata[0], 32'h0);
    step(0, 4'b0010, 32'h0);
    step(0, 4'b0010, 32'h0);
    step(0, 4'b0010, 32'h0);
    check("rw core1 done stall", 32'(core_stall), 32'h0);

    // Two cores contending with stall counters.
    step(1, 4'b0000, 32'h0);
    step(0, 4'b0011, 32'h0);
    check("st t stall", 32'(core_stall), 32'h3);
    step(0, 4'b0011, 32'h0);
    step(0, 4'b0011, 32'h0);
    step(0, 4'b0011, 32'h0);
    check("st core0 done stall", 32'(core_stall), 32'h2);
    step(0, 4'b0010, 32'h0);
    step(0, 4'b0010, 32'h0);
    step(0, 4'b0010, 32'h0);
    step(0, 4'b0010, 32'h0);
    check("st core1 done stall", 32'(core_stall), 32'h0);
    check("st core1 grant", 32'(grant), 32'h1);
    step(0, 4'b0000, 32'h0);
`ifdef CORE_ARB_STATS_EN
    check("stat[0]", stat[0], 32'd3);
    check("stat[1]", stat[1], 32'd7);
`else
    check("stat[0]", stat[0], 32'd0);
    check("stat[1]", stat[1], 32'd0);
`endif
    check("stat[2]", stat[2], 32'd0);
    check("stat[3]", stat[3], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
